// File: rtl/alu_operand_stage.sv
// alu_operand_stage: two-entry (head + skid) operand staging buffer in front of
// the execute-stage ALU. Operands are resolved against the MEM and WB forwarding
// buses at capture, and held entries keep snooping those buses while stalled.
// in_ready and out_valid are decoded purely from registered occupancy state, so
// ALU back-pressure never reaches decode through a combinational path.
module alu_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int OP_WIDTH       = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_WIDTH-1:0]       in_op,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0]     in_rs1_data,
    input  logic [DATA_WIDTH-1:0]     in_rs2_data,
    input  logic [DATA_WIDTH-1:0]     in_imm,
    input  logic                      in_use_imm,
    input  logic                      fwd_mem_valid,
    input  logic [REG_ADDR_WIDTH-1:0] fwd_mem_rd,
    input  logic [DATA_WIDTH-1:0]     fwd_mem_data,
    input  logic                      fwd_wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] fwd_wb_rd,
    input  logic [DATA_WIDTH-1:0]     fwd_wb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OP_WIDTH-1:0]       out_op,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic [DATA_WIDTH-1:0]     out_a,
    output logic [DATA_WIDTH-1:0]     out_b
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_WIDTH-1:0]       op;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic                      use_imm;
        logic [DATA_WIDTH-1:0]     a;
        logic [DATA_WIDTH-1:0]     b;
    } entry_t;

    state_t state;
    entry_t head;
    entry_t skid;
    entry_t cap_entry;
    entry_t head_snoop;
    entry_t skid_snoop;
    logic   push;
    logic   pop;

    // MEM wins over WB; register 0 never forwards, so the current value stands.
    function automatic logic [DATA_WIDTH-1:0] resolve(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [DATA_WIDTH-1:0]     cur,
        input logic                      mem_v,
        input logic [REG_ADDR_WIDTH-1:0] mem_rd,
        input logic [DATA_WIDTH-1:0]     mem_data,
        input logic                      wb_v,
        input logic [REG_ADDR_WIDTH-1:0] wb_rd,
        input logic [DATA_WIDTH-1:0]     wb_data
    );
        logic [DATA_WIDTH-1:0] res;
        res = cur;
        if (rs != '0) begin
            if (mem_v && (mem_rd == rs)) begin
                res = mem_data;
            end else if (wb_v && (wb_rd == rs)) begin
                res = wb_data;
            end
        end
        return res;
    endfunction

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_op    = head.op;
    assign out_rd    = head.rd;
    assign out_a     = head.a;
    assign out_b     = head.b;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready;

    // Build the entry offered by decode with its operands already forwarded.
    always_comb begin
        cap_entry         = '0;
        cap_entry.op      = in_op;
        cap_entry.rd      = in_rd;
        cap_entry.rs1     = in_rs1;
        cap_entry.rs2     = in_rs2;
        cap_entry.use_imm = in_use_imm;
        cap_entry.a       = resolve(in_rs1, in_rs1_data,
                                    fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                                    fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        cap_entry.b       = in_use_imm ? in_imm :
                            resolve(in_rs2, in_rs2_data,
                                    fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                                    fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    end

    // Refresh held operands from this cycle's forwarding buses; immediates stay put.
    always_comb begin
        head_snoop   = head;
        skid_snoop   = skid;
        head_snoop.a = resolve(head.rs1, head.a,
                               fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                               fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        skid_snoop.a = resolve(skid.rs1, skid.a,
                               fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                               fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        if (!head.use_imm) begin
            head_snoop.b = resolve(head.rs2, head.b,
                                   fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                                   fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        end
        if (!skid.use_imm) begin
            skid_snoop.b = resolve(skid.rs2, skid.b,
                                   fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                                   fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        end
    end

    // Occupancy FSM and entry storage; entries default to their snooped values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            head <= head_snoop;
            skid <= skid_snoop;
            if (flush) begin
                state <= EMPTY;
            end else begin
                unique case (state)
                    EMPTY: begin
                        if (push) begin
                            head  <= cap_entry;
                            state <= ONE;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            head <= cap_entry;
                        end else if (push) begin
                            skid  <= cap_entry;
                            state <= FULL;
                        end else if (pop) begin
                            state <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            head  <= skid_snoop;
                            state <= ONE;
                        end
                    end
                    default: begin
                        state <= EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed stimulus against a queue-based model of the
// operand stage, compared every cycle, plus hand-computed literal expectations.
module tb_alu_operand_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [4:0]  inOp;
    logic [4:0]  inRs1;
    logic [4:0]  inRs2;
    logic [4:0]  inRd;
    logic [31:0] inRs1Data;
    logic [31:0] inRs2Data;
    logic [31:0] inImm;
    logic        inUseImm;
    logic        memValid;
    logic [4:0]  memRd;
    logic [31:0] memData;
    logic        wbValid;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    logic        outValid;
    logic        outReady;
    logic [4:0]  outOp;
    logic [4:0]  outRd;
    logic [31:0] outA;
    logic [31:0] outB;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        useImm;
        logic [31:0] a;
        logic [31:0] b;
    } entryT;

    entryT modelQ[$];

    alu_operand_stage dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (inValid),
        .in_ready     (inReady),
        .in_op        (inOp),
        .in_rs1       (inRs1),
        .in_rs2       (inRs2),
        .in_rd        (inRd),
        .in_rs1_data  (inRs1Data),
        .in_rs2_data  (inRs2Data),
        .in_imm       (inImm),
        .in_use_imm   (inUseImm),
        .fwd_mem_valid(memValid),
        .fwd_mem_rd   (memRd),
        .fwd_mem_data (memData),
        .fwd_wb_valid (wbValid),
        .fwd_wb_rd    (wbRd),
        .fwd_wb_data  (wbData),
        .out_valid    (outValid),
        .out_ready    (outReady),
        .out_op       (outOp),
        .out_rd       (outRd),
        .out_a        (outA),
        .out_b        (outB)
    );

    always #5 clock = ~clock;

    // Counted comparison with a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one decode offer (valid=0 means idle bus).
    task automatic applyStimulus(input logic v, input logic [4:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [31:0] imm, input logic useImm);
        inValid   = v;
        inOp      = op;
        inRd      = rd;
        inRs1     = rs1;
        inRs2     = rs2;
        inRs1Data = d1;
        inRs2Data = d2;
        inImm     = imm;
        inUseImm  = useImm;
    endtask

    task automatic setFwd(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                          input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
        memValid = mv;
        memRd    = mrd;
        memData  = md;
        wbValid  = wv;
        wbRd     = wrd;
        wbData   = wd;
    endtask

    // Architectural forwarding rule: MEM first, then WB, never for register 0.
    function automatic logic [31:0] fwdValue(input logic [4:0] rs, input logic [31:0] cur);
        if (rs == 5'd0) return cur;
        if (memValid && memRd == rs) return memData;
        if (wbValid && wbRd == rs) return wbData;
        return cur;
    endfunction

    // Model: a FIFO of at most two instructions, updated at each rising edge.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            modelQ.delete();
        end else begin
            int    n;
            bit    popM;
            bit    pushM;
            entryT e;
            n     = modelQ.size();
            popM  = (n > 0) && outReady;
            pushM = inValid && (n < 2) && !flush;
            e.op     = inOp;
            e.rd     = inRd;
            e.rs1    = inRs1;
            e.rs2    = inRs2;
            e.useImm = inUseImm;
            e.a      = fwdValue(inRs1, inRs1Data);
            e.b      = inUseImm ? inImm : fwdValue(inRs2, inRs2Data);
            foreach (modelQ[i]) begin
                modelQ[i].a = fwdValue(modelQ[i].rs1, modelQ[i].a);
                if (!modelQ[i].useImm) modelQ[i].b = fwdValue(modelQ[i].rs2, modelQ[i].b);
            end
            if (popM) void'(modelQ.pop_front());
            if (flush) modelQ.delete();
            if (pushM) modelQ.push_back(e);
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        checkOutput("in_ready", 32'(inReady), 32'(modelQ.size() < 2));
        checkOutput("out_valid", 32'(outValid), 32'(modelQ.size() > 0));
        if (modelQ.size() > 0) begin
            checkOutput("out_op", 32'(outOp), 32'(modelQ[0].op));
            checkOutput("out_rd", 32'(outRd), 32'(modelQ[0].rd));
            checkOutput("out_a", outA, modelQ[0].a);
            checkOutput("out_b", outB, modelQ[0].b);
        end
    end

    initial begin
        flush    = 1'b0;
        outReady = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        setFwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #3;
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_in_ready", 32'(inReady), 32'd1);
        checkOutput("rst_out_a", outA, 32'd0);
        checkOutput("rst_out_b", outB, 32'd0);
        #9 reset = 1'b0;

        // Stream: one per cycle, one-cycle latency.
        outReady = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clock);
            if (i > 1) begin
                checkOutput("stream_a", outA, 32'(i - 1));
                checkOutput("stream_valid", 32'(outValid), 32'd1);
                checkOutput("stream_ready", 32'(inReady), 32'd1);
            end
            if (i <= 8)
                applyStimulus(1'b1, 5'(i), 5'(i + 10), 5'd1, 5'd2, 32'(i), 32'(i * 3), 32'd0, 1'b0);
            else
                applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        end

        // Back-pressure: fill, offer a third, then drain in order.
        @(negedge clock);
        outReady = 1'b0;
        applyStimulus(1'b1, 5'd3, 5'd4, 5'd6, 5'd8, 32'hA, 32'h1A, 32'd0, 1'b0);
        @(negedge clock);
        applyStimulus(1'b1, 5'd4, 5'd5, 5'd6, 5'd8, 32'hB, 32'h1B, 32'd0, 1'b0);
        @(negedge clock);
        checkOutput("bp_full_ready", 32'(inReady), 32'd0);
        checkOutput("bp_head_a", outA, 32'hA);
        applyStimulus(1'b1, 5'd5, 5'd6, 5'd6, 5'd8, 32'hC, 32'h1C, 32'd0, 1'b0);
        @(negedge clock);
        checkOutput("bp_third_ready", 32'(inReady), 32'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        outReady = 1'b1;
        @(negedge clock);
        checkOutput("bp_second_a", outA, 32'hB);
        checkOutput("bp_ready_back", 32'(inReady), 32'd1);
        @(negedge clock);
        checkOutput("bp_drained", 32'(outValid), 32'd0);

        // Forwarding priority at capture.
        applyStimulus(1'b1, 5'd1, 5'd9, 5'd5, 5'd0, 32'h11, 32'h0, 32'd0, 1'b0);
        setFwd(1'b1, 5'd5, 32'h22, 1'b1, 5'd5, 32'h33);
        @(negedge clock);
        checkOutput("fwd_mem_prio", outA, 32'h22);
        setFwd(1'b0, 5'd5, 32'h22, 1'b1, 5'd5, 32'h33);
        @(negedge clock);
        checkOutput("fwd_wb", outA, 32'h33);
        applyStimulus(1'b1, 5'd1, 5'd9, 5'd0, 5'd0, 32'h11, 32'h0, 32'd0, 1'b0);
        setFwd(1'b1, 5'd0, 32'h22, 1'b1, 5'd0, 32'h33);
        @(negedge clock);
        checkOutput("fwd_r0", outA, 32'h11);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        setFwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Stall snoop on a register operand, then on an immediate.
        @(negedge clock);
        outReady = 1'b0;
        applyStimulus(1'b1, 5'd7, 5'd3, 5'd2, 5'd7, 32'h5, 32'h1, 32'h5555, 1'b0);
        @(negedge clock);
        checkOutput("snoop_pre_b", outB, 32'h1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        setFwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hABCD);
        @(negedge clock);
        checkOutput("snoop_b", outB, 32'hABCD);
        setFwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        outReady = 1'b1;
        @(negedge clock);
        outReady = 1'b0;
        applyStimulus(1'b1, 5'd8, 5'd3, 5'd2, 5'd7, 32'h5, 32'h1, 32'h5555, 1'b1);
        @(negedge clock);
        checkOutput("imm_pre_b", outB, 32'h5555);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        setFwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hABCD);
        @(negedge clock);
        checkOutput("imm_keep_b", outB, 32'h5555);
        setFwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        outReady = 1'b1;
        @(negedge clock);

        // Flush while full with an offer pending.
        outReady = 1'b0;
        applyStimulus(1'b1, 5'd9, 5'd1, 5'd3, 5'd4, 32'h70, 32'h71, 32'd0, 1'b0);
        @(negedge clock);
        applyStimulus(1'b1, 5'd10, 5'd2, 5'd3, 5'd4, 32'h72, 32'h73, 32'd0, 1'b0);
        @(negedge clock);
        applyStimulus(1'b1, 5'd11, 5'd3, 5'd3, 5'd4, 32'h74, 32'h75, 32'd0, 1'b0);
        flush = 1'b1;
        @(negedge clock);
        checkOutput("flush_valid", 32'(outValid), 32'd0);
        checkOutput("flush_ready", 32'(inReady), 32'd1);
        flush = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        outReady = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("flush_dropped", 32'(outValid), 32'd0);

        // Asynchronous reset between edges while full.
        outReady = 1'b0;
        applyStimulus(1'b1, 5'd12, 5'd1, 5'd3, 5'd4, 32'h80, 32'h81, 32'd0, 1'b0);
        @(negedge clock);
        applyStimulus(1'b1, 5'd13, 5'd2, 5'd3, 5'd4, 32'h82, 32'h83, 32'd0, 1'b0);
        @(negedge clock);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("pre_rst_ready", 32'(inReady), 32'd0);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(outValid), 32'd0);
        checkOutput("arst_ready", 32'(inReady), 32'd1);
        checkOutput("arst_out_op", 32'(outOp), 32'd0);
        checkOutput("arst_out_a", outA, 32'd0);
        #1 reset = 1'b0;

        // Resume streaming after reset.
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i > 0) checkOutput("resume_a", outA, 32'(32'h90 + i - 1));
            if (i < 3)
                applyStimulus(1'b1, 5'(i + 20), 5'(i + 1), 5'd4, 5'd5, 32'(32'h90 + i), 32'h0, 32'd0, 1'b0);
            else
                applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        end
        repeat (2) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand staging buffer directly upstream of the execute-stage ALU. It accepts decoded instructions from decode with a valid/ready handshake and resolves both source operands against the MEM and WB forwarding buses. It holds up to two instructions in a main + skid buffer so back-pressure from the ALU never creates a combinational ready path. Held entries keep snooping the forwarding buses while stalled, so operands presented to the ALU are always current.

## Interface
- DATA_WIDTH, 32, operand/result width
- REG_ADDR_WIDTH, 5, register index width; index 0 is the hard-wired zero register
- OP_WIDTH, 5, ALU opcode width
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  discard all held and offered instructions
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage can accept; registered
- in_op  in  OP_WIDTH  ALU opcode
- in_rs1, in_rs2, in_rd  in  REG_ADDR_WIDTH  source/destination indices
- in_rs1_data, in_rs2_data  in  DATA_WIDTH  register-file read data
- in_imm  in  DATA_WIDTH  sign-extended immediate
- in_use_imm  in  1  operand B is in_imm; rs2 is ignored
- fwd_mem_valid, fwd_wb_valid  in  1  forwarding source carries a register write
- fwd_mem_rd, fwd_wb_rd  in  REG_ADDR_WIDTH  destination of that write
- fwd_mem_data, fwd_wb_data  in  DATA_WIDTH  value of that write
- out_valid  out  1  head entry presented to ALU
- out_ready  in  1  ALU consumes head entry
- out_op  out  OP_WIDTH, out_rd  out  REG_ADDR_WIDTH, out_a, out_b  out  DATA_WIDTH  head-entry fields

## Operation
- Entries: head (drives outputs) and skid. Each entry stores op, rd, rs1, rs2, use_imm, a, b.
- States: EMPTY (0 entries), ONE, FULL (2 entries).
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- EMPTY: push -> ONE (data into head).
- ONE: push only -> FULL (data into skid). Pop only -> EMPTY. Push + pop -> ONE (new data into head).
- FULL: pop -> ONE (skid moves to head). No push is possible because in_ready = 0.
- in_ready = (state != FULL). out_valid = (state != EMPTY). Both are decoded from registered state only.
- Forwarding on capture:
  - Operand A: fwd_mem_data if fwd_mem_valid & fwd_mem_rd == rs1 & rs1 != 0; else fwd_wb_data on the same WB match; else in_rs1_data.
  - Operand B: same rule using rs2 and in_rs2_data. If use_imm, B = in_imm with no forwarding.
  - MEM has priority over WB. rs == 0 always yields in_rsX_data.
- Snoop: every cycle, each held entry applies the same match/priority rule to its stored rs1/rs2. On a match it overwrites a/b (b only if !use_imm). An entry moving skid -> head carries its snoop-updated values.
- Flush:
  - Next state EMPTY.
  - Flush has priority over push; an offered instruction is dropped even if in_ready = 1.
  - A pop in the flush cycle completes normally at the consumer.

## Timing
- Reset (async assert): state EMPTY, in_ready = 1, out_valid = 0, out_op/out_rd/out_a/out_b = 0, skid fields = 0.
- Latency: instruction pushed at edge N appears on outputs with out_valid = 1 after edge N (cycle N+1).
- Throughput: one instruction per cycle while out_ready = 1.
- in_ready falls the cycle after the second entry is captured while out_ready = 0. It rises the cycle after the pop that leaves FULL.
- Snoop updates are visible on out_a/out_b the cycle after the forwarding match.
- out_* fields must stay stable while out_valid & !out_ready, except for snoop updates.
- Flush at edge N: out_valid = 0 and in_ready = 1 from cycle N+1.
- Reset mid-operation: all entries are lost, and the reset values above apply immediately.

## Test plan
- Stream: out_ready = 1, push ops with rs1_data = 1..8 on consecutive cycles -> out_a = 1..8 on consecutive cycles, one-cycle latency, in_ready constantly 1.
- Back-pressure: out_ready = 0, push A then B -> state FULL, in_ready = 0. Third offer is not accepted. Raise out_ready -> A then B emitted in order, in_ready = 1 one cycle after A pops.
- Forward priority: rs1 = 5, in_rs1_data = 0x11, MEM rd 5 = 0x22, WB rd 5 = 0x33 -> out_a = 0x22. With MEM invalid -> 0x33. With rs1 = 0 and both buses at rd 0 -> 0x11.
- Stall snoop: head holds rs2 = 7 with out_ready = 0; WB writes rd 7 = 0xABCD -> out_b = 0xABCD the next cycle. Same case with use_imm = 1 -> out_b keeps the immediate.
- Flush: state FULL plus in_valid = 1 and flush = 1 -> next cycle out_valid = 0, in_ready = 1, offered instruction never emitted.
- Async reset mid-stream: assert reset between edges while FULL -> out_valid = 0 and in_ready = 1 before the next edge. Stream resumes cleanly after deassert.
